// File: rtl/seven_seg_pkg.sv
// seven_seg_pkg: active-high digit patterns and scan monitor state type
package seven_seg_pkg;

   localparam logic [6:0] SEG_DIGIT [10] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
   };
   localparam logic [6:0] SEG_BLANK = 7'h00;

   typedef enum logic [1:0] {IDLE, SETTLE, HELD} scan_state_e;

endpackage

// File: rtl/seven_segment_scan_capture_if.sv
// seven_segment_scan_capture_if: scanned display pins and reassembled BCD results
interface seven_segment_scan_capture_if;

   logic [6:0] seg_in;
   logic [1:0] an_in;
   logic [7:0] bcd_out;
   logic       bcd_valid;
   logic       bcd_changed;
   logic       seg_error;
   logic       scan_stall;

   modport master (
      output seg_in, an_in,
      input  bcd_out, bcd_valid, bcd_changed, seg_error, scan_stall
   );

   modport slave (
      input  seg_in, an_in,
      output bcd_out, bcd_valid, bcd_changed, seg_error, scan_stall
   );

endinterface

// File: rtl/seven_seg_pattern_decode.sv
// seven_seg_pattern_decode: active-high g..a pattern to BCD nibble, 4'hF when not a digit
module seven_seg_pattern_decode
   import seven_seg_pkg::*;
(
   input  logic [6:0] pattern,
   output logic [3:0] nibble,
   output logic       legal
);

   always_comb begin
      nibble = 4'hF;
      legal  = 1'b0;
      if (pattern != SEG_BLANK)
         for (int i = 0; i < 10; i++)
            if (pattern == SEG_DIGIT[i]) begin
               nibble = 4'(i);
               legal  = 1'b1;
            end
   end

endmodule

// File: rtl/seven_segment_scan_capture.sv
// seven_segment_scan_capture: passive monitor rebuilding the BCD value behind a two-digit scan
module seven_segment_scan_capture
   import seven_seg_pkg::*;
#(
   parameter int SETTLE_CYCLES  = 4,
   parameter int STALL_CYCLES   = 1000000,
   parameter bit SEG_ACTIVE_LOW = 1'b1,
   parameter bit AN_ACTIVE_LOW  = 1'b1
) (
   input logic                         clk,
   input logic                         reset,
   seven_segment_scan_capture_if.slave bus
);

   localparam int STALL_W = $clog2(STALL_CYCLES + 1);
   localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(STALL_CYCLES);

   logic [8:0]         samp_q, prev_q;
   logic [7:0]         cnt_q, cnt_d;
   scan_state_e        state_q, state_d;
   logic [3:0]         lo_q, hi_q, nibble;
   logic               seen_lo_q, seen_hi_q, out_done_q, legal;
   logic [STALL_W-1:0] stall_q;
   logic [1:0]         an;
   logic [6:0]         seg;
   logic               one_hot, diff, cap, both;

   // raw pins are compared for stability; polarity only matters for decoding
   assign an      = AN_ACTIVE_LOW ? ~samp_q[8:7] : samp_q[8:7];
   assign seg     = SEG_ACTIVE_LOW ? ~samp_q[6:0] : samp_q[6:0];
   assign one_hot = an[0] ^ an[1];
   assign diff    = samp_q != prev_q;
   assign cap     = state_q == SETTLE && !diff && cnt_q == 8'(SETTLE_CYCLES - 1);
   assign both    = seen_lo_q && seen_hi_q;
   assign bus.scan_stall = stall_q == STALL_MAX;

   seven_seg_pattern_decode u_decode (
      .pattern (seg),
      .nibble  (nibble),
      .legal   (legal)
   );

   always_comb begin
      cnt_d   = (diff || state_q == IDLE) ? 8'd0 :
                (cnt_q == 8'(SETTLE_CYCLES) ? cnt_q : cnt_q + 8'd1);
      state_d = (diff || state_q == IDLE) ? (one_hot ? SETTLE : IDLE) :
                (cap ? HELD : state_q);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         samp_q          <= '0;
         prev_q          <= '0;
         cnt_q           <= '0;
         state_q         <= IDLE;
         lo_q            <= '0;
         hi_q            <= '0;
         seen_lo_q       <= 1'b0;
         seen_hi_q       <= 1'b0;
         out_done_q      <= 1'b0;
         stall_q         <= '0;
         bus.bcd_out     <= '0;
         bus.bcd_valid   <= 1'b0;
         bus.bcd_changed <= 1'b0;
         bus.seg_error   <= 1'b0;
      end else begin
         samp_q          <= {bus.an_in, bus.seg_in};
         prev_q          <= samp_q;
         cnt_q           <= cnt_d;
         state_q         <= state_d;
         stall_q         <= cap ? '0 : (stall_q == STALL_MAX ? stall_q : stall_q + STALL_W'(1));
         bus.seg_error   <= cap && !legal;
         bus.bcd_valid   <= both;
         bus.bcd_changed <= both && (!out_done_q || {hi_q, lo_q} != bus.bcd_out);
         if (both) begin
            bus.bcd_out <= {hi_q, lo_q};
            seen_lo_q   <= 1'b0;
            seen_hi_q   <= 1'b0;
            out_done_q  <= 1'b1;
         end
         // a repeated capture of one slot simply overwrites it until the other arrives
         if (cap && an[0]) begin
            lo_q      <= nibble;
            seen_lo_q <= 1'b1;
         end
         if (cap && an[1]) begin
            hi_q      <= nibble;
            seen_hi_q <= 1'b1;
         end
      end
   end

endmodule
